fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline registers.
- Generates the PC and drives a single-outstanding request/response instruction-memory port.
- Buffers the returned word and presents {fetch_pc, fetch_instr, fetch_valid} to IF/ID, which captures them whenever the stage is not stalled.
- Handles pipeline stall (the IF/ID enable is ~stall) and branch/jump redirect with flush of in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, word driven on fetch_instr when fetch_valid=0 (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
stall  in  1  1 = IF/ID not capturing this cycle
redirect  in  1  1 = flush and restart fetch at redirect_pc
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle (meaningful only when imem_req=1)
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction word
fetch_pc  out  32  PC of presented instruction
fetch_instr  out  32  presented instruction, NOP_INSTR when invalid
fetch_valid  out  1  presented instruction is real

Behaviour:
- Registers:
  - pc: next fetch address.
  - state: ISSUE, WAIT, HOLD.
  - kill: discard next response.
  - slot: fetch_valid/pc/instr.
  - hold: 1-deep skid (hold_pc, hold_instr).
- Reset (async, immediate on rst rise):
  - pc=RESET_PC, state=ISSUE, kill=0.
  - fetch_valid=0, fetch_pc=0, fetch_instr=NOP_INSTR.
  - imem_req forced 0 while rst=1.
- Outputs:
  - imem_req = (state==ISSUE) & ~rst.
  - imem_addr = {pc[31:2],2'b00}.
- Slot consumed in any cycle with stall=0 and fetch_valid=1. Slot cleared when consumed and not refilled the same cycle.
- ISSUE: on imem_gnt, record issued_pc=pc, pc<=pc+4 (mod 2^32), go WAIT. Without gnt, hold imem_req/imem_addr stable.
- WAIT: imem_req=0. On imem_rvalid:
  - kill=1: drop the data, kill<=0, go ISSUE.
  - Slot empty or consumed this cycle: slot<={1,issued_pc,imem_rdata}, go ISSUE.
  - Otherwise: hold<={issued_pc,imem_rdata}, go HOLD.
- HOLD: imem_req=0. When the slot is consumed, slot<=hold (valid), go ISSUE.
- imem_rvalid outside WAIT is ignored.
- Memory contract: rvalid no earlier than the cycle after gnt.
- Minimum latency: 1 cycle from gnt to rvalid; fetch_valid rises on the edge after rvalid. Peak throughput is 1 instruction per 2 cycles.
- Redirect: highest priority; overrides all of the above in that cycle.
  - pc<={redirect_pc[31:2],2'b00} (no +4).
  - Slot valid<=0; hold discarded. fetch_valid=0 from the next cycle, regardless of stall.
  - ISSUE without gnt: stay ISSUE; new address presented next cycle.
  - ISSUE with gnt the same cycle: go WAIT with kill=1.
  - WAIT without rvalid: stay WAIT, kill<=1.
  - WAIT with rvalid the same cycle: drop the response, kill<=0, go ISSUE.
  - HOLD: go ISSUE.
- Stall alone never drops or duplicates an instruction. Every granted, non-killed response is presented exactly once, in issue order.
- Invalid-slot contents: when fetch_valid=0, fetch_instr=NOP_INSTR and fetch_pc retains its last value. IF/ID therefore captures bubbles as NOP.
- Reset mid-operation: all state is lost. The memory must be reset together with this block; a response to a pre-reset request is not tolerated.

Test Plan:
- Reset/stream: RESET_PC=0x100; gnt=1 always, rvalid one cycle after gnt with rdata=addr^0xAA00 -> imem_addr sequence 0x100, 0x104, 0x108; fetch_valid pulses each show the matching pc/instr in order; fetch_instr=0x00000013 between pulses.
- Stall/skid: stall=1 for 6 cycles while the 0x104 slot is full and the 0x108 response arrives -> state HOLD, imem_req=0. On release, 0x104 then 0x108 are presented on consecutive consumed cycles; no loss, no duplication.
- Redirect in WAIT: redirect=1, redirect_pc=0x2003 while waiting on 0x10C; response arrives 3 cycles later -> that response is dropped, next imem_addr=0x2000, fetch_valid stays 0 until the 0x2000 instruction.
- Redirect coincident with gnt: redirect=1 (0x400) in the same cycle as gnt for 0x110 -> the 0x110 response is dropped, the next request is 0x400, and fetch_pc never shows 0x110.
- Wrap: redirect to 0xFFFFFFFC, stream -> imem_addr 0xFFFFFFFC then 0x00000000.
- Async reset mid-WAIT: assert rst between clock edges -> fetch_valid=0, fetch_instr=0x00000013 and imem_req=0 immediately without a clock edge; after release, the first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus: single outstanding request,
// gnt accepts the request, rvalid/rdata return the word at least one cycle later.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding IF/ID: PC generation, single-outstanding imem
// port, one-entry output slot with a one-deep skid, stall and redirect/flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  fetch_unit_if.master imem,
  output logic [31:0]  fetch_pc_o,
  output logic [31:0]  fetch_instr_o,
  output logic         fetch_valid_o
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] issued_pc_q, issued_pc_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_instr_q, slot_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic        consume;

  assign consume       = valid_q & ~stall_i;
  assign imem.req      = (state_q == ISSUE) & ~rst;
  assign imem.addr     = {pc_q[31:2], 2'b00};
  assign fetch_valid_o = valid_q;
  assign fetch_pc_o    = slot_pc_q;
  assign fetch_instr_o = valid_q ? slot_instr_q : NOP_INSTR;

  // NOTE: every next-state signal gets its hold value first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    issued_pc_d  = issued_pc_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    kill_d       = kill_q;
    valid_d      = valid_q;

    if (redirect_i) begin
      // Flush: the slot and skid are dropped, and whatever is in flight is killed.
      pc_d    = redirect_pc_i & 32'hFFFF_FFFC;
      valid_d = 1'b0;
      case (state_q)
        ISSUE: if (imem.gnt) begin
          state_d = WAIT;
          kill_d  = 1'b1;
        end
        WAIT: begin
          if (imem.rvalid) begin
            state_d = ISSUE;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: state_d = ISSUE;
      endcase
    end else begin
      if (consume) valid_d = 1'b0;
      case (state_q)
        ISSUE: if (imem.gnt) begin
          issued_pc_d = pc_q;
          pc_d        = pc_q + 32'd4;
          state_d     = WAIT;
        end
        WAIT: if (imem.rvalid) begin
          state_d = ISSUE;
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (!valid_q || consume) begin
            valid_d      = 1'b1;
            slot_pc_d    = issued_pc_q;
            slot_instr_d = imem.rdata;
          end else begin
            hold_pc_d    = issued_pc_q;
            hold_instr_d = imem.rdata;
            state_d      = HOLD;
          end
        end
        HOLD: if (consume) begin
          valid_d      = 1'b1;
          slot_pc_d    = hold_pc_q;
          slot_instr_d = hold_instr_q;
          state_d      = ISSUE;
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ISSUE;
      pc_q         <= RESET_PC;
      issued_pc_q  <= '0;
      slot_pc_q    <= '0;
      slot_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      kill_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      issued_pc_q  <= issued_pc_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      kill_q       <= kill_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a memory model plus a queue of expected
// (pc, instr) presentations derived from grants, responses and redirects.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_valid;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem),
    .fetch_pc_o    (fetch_pc),
    .fetch_instr_o (fetch_instr),
    .fetch_valid_o (fetch_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t       exp_q[$];
  int          checks    = 0;
  int          failures  = 0;
  int          presented = 0;
  logic [31:0] exp_addr;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [31:0] prev_granted;
  bit          outst, killed, prev_redir, last_gnt, wrap_ok;
  int          dly;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    outst      = 1'b0;
    killed     = 1'b0;
    prev_redir = 1'b0;
    last_gnt   = 1'b0;
    exp_addr   = RESET_PC;
  endtask

  // One clock of stimulus plus reference-model bookkeeping. Inputs change and
  // outputs are sampled around the falling edge.
  task automatic run_cycle(input int stall_pct, input int gnt_pct, input int redir_pct,
                           input int max_dly, input bit redir_on_gnt, input logic [31:0] tgt);
    bit          rv, g, s, r;
    logic [31:0] t;
    item_t       it;
    @(negedge clk);
    rv = outst && (dly == 0);
    g  = imem.req && (int'($urandom_range(99)) < gnt_pct);
    s  = int'($urandom_range(99)) < stall_pct;
    r  = (redir_on_gnt && g) || (int'($urandom_range(99)) < redir_pct);
    if (redir_on_gnt)                  t = tgt;
    else if ($urandom_range(7) == 0)   t = 32'hFFFF_FFFD;
    else                               t = $urandom;
    stall       = s;
    redirect    = r;
    redirect_pc = t;
    imem.gnt    = g;
    imem.rvalid = rv;
    imem.rdata  = rv ? out_data : $urandom;
    #1;
    if (prev_redir)  check("valid_after_redirect", {31'b0, fetch_valid}, 32'd0);
    if (!fetch_valid) check("nop_when_invalid", fetch_instr, NOP);
    if (imem.req)    check("imem_addr", imem.addr, exp_addr);
    if (fetch_valid && !s) begin
      if (exp_q.size() == 0) begin
        check("unexpected_presentation", {31'b0, fetch_valid}, 32'd0);
      end else begin
        it = exp_q.pop_front();
        check("fetch_pc", fetch_pc, it.pc);
        check("fetch_instr", fetch_instr, it.instr);
        presented++;
      end
    end
    if (rv) begin
      if (!r && !killed) exp_q.push_back({out_addr, out_data});
      outst = 1'b0;
    end else if (outst) begin
      dly--;
    end
    last_gnt = g;
    if (g) begin
      if (imem.addr == 32'h0 && prev_granted == 32'hFFFF_FFFC) wrap_ok = 1'b1;
      prev_granted = imem.addr;
      outst    = 1'b1;
      killed   = 1'b0;
      out_addr = imem.addr;
      out_data = $urandom;
      dly      = int'($urandom_range(max_dly));
      exp_addr = imem.addr + 32'd4;
    end
    if (r) begin
      exp_q.delete();
      exp_addr = t & 32'hFFFF_FFFC;
      if (outst) killed = 1'b1;
    end
    prev_redir = r;
  endtask

  initial begin
    bit found;
    rst          = 1'b1;
    stall        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    imem.gnt     = 1'b0;
    imem.rvalid  = 1'b0;
    imem.rdata   = '0;
    prev_granted = '0;
    wrap_ok      = 1'b0;
    reset_model();

    #1;
    check("reset_req", {31'b0, imem.req}, 32'd0);
    check("reset_valid", {31'b0, fetch_valid}, 32'd0);
    check("reset_instr", fetch_instr, NOP);
    check("reset_pc", fetch_pc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_req", {31'b0, imem.req}, 32'd1);
    check("first_addr", imem.addr, RESET_PC);

    // Plain stream: always granted, shortest latency, no stall.
    for (int i = 0; i < 40; i++) run_cycle(0, 100, 0, 0, 1'b0, '0);

    // Long stall with slot and skid filling up: fetch must park with req low.
    for (int i = 0; i < 12; i++) run_cycle(100, 100, 0, 0, 1'b0, '0);
    check("skid_req_low", {31'b0, imem.req}, 32'd0);
    check("skid_valid", {31'b0, fetch_valid}, 32'd1);
    for (int i = 0; i < 10; i++) run_cycle(0, 100, 0, 0, 1'b0, '0);

    // Redirect coincident with a grant, repeated a few times.
    for (int i = 0; i < 20; i++) run_cycle(20, 100, 0, 2, 1'b1, 32'h0000_0400 + 32'(i));

    // Wrap across the top of the address space.
    run_cycle(0, 0, 100, 0, 1'b0, '0);
    while (exp_addr != 32'hFFFF_FFFC) run_cycle(0, 0, 100, 0, 1'b0, '0);
    for (int i = 0; i < 10; i++) run_cycle(0, 100, 0, 0, 1'b0, '0);
    check("wrap_to_zero", {31'b0, wrap_ok}, 32'd1);

    // Random mix of stall, grant back-pressure, latency and redirects.
    for (int i = 0; i < 3000; i++) run_cycle(30, 70, 5, 3, 1'b0, '0);

    // Asynchronous reset with a request outstanding and the slot full.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      run_cycle(100, 100, 0, 3, 1'b0, '0);
      found = last_gnt && fetch_valid;
    end
    check("reach_wait_full", {31'b0, found}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", {31'b0, fetch_valid}, 32'd0);
    check("async_instr", fetch_instr, NOP);
    check("async_req", {31'b0, imem.req}, 32'd0);
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    stall       = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    #1;
    check("addr_after_reset", imem.addr, RESET_PC);
    for (int i = 0; i < 200; i++) run_cycle(30, 70, 5, 3, 1'b0, '0);

    // Drain: no more grants, everything owed must come out.
    for (int i = 0; i < 30; i++) run_cycle(0, 0, 0, 3, 1'b0, '0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", {31'b0, fetch_valid}, 32'd0);
    check("progress", {31'b0, presented > 200}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
